// File: rtl/game_pkg.sv
// Shared encodings for the 2048 game: command codes, PS/2 scan codes and the
// keyboard receiver state type.
package game_pkg;

   localparam logic [2:0] CMD_UP      = 3'd0;
   localparam logic [2:0] CMD_DOWN    = 3'd1;
   localparam logic [2:0] CMD_LEFT    = 3'd2;
   localparam logic [2:0] CMD_RIGHT   = 3'd3;
   localparam logic [2:0] CMD_RESTART = 3'd4;

   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_BRK     = 8'hF0;
   localparam logic [7:0] SC_E_UP    = 8'h75;
   localparam logic [7:0] SC_E_DOWN  = 8'h72;
   localparam logic [7:0] SC_E_LEFT  = 8'h6B;
   localparam logic [7:0] SC_E_RIGHT = 8'h74;
   localparam logic [7:0] SC_W       = 8'h1D;
   localparam logic [7:0] SC_S       = 8'h1B;
   localparam logic [7:0] SC_A       = 8'h1C;
   localparam logic [7:0] SC_D       = 8'h23;
   localparam logic [7:0] SC_R       = 8'h2D;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] code;
   } cmd_t;

   // Map a make code (with the E0 prefix flag) to a game command.
   function automatic cmd_t decode_scan(input logic [7:0] sc, input logic ext);
      cmd_t c;
      c.hit  = 1'b1;
      c.code = CMD_UP;
      if (ext) begin
         case (sc)
            SC_E_UP:    c.code = CMD_UP;
            SC_E_DOWN:  c.code = CMD_DOWN;
            SC_E_LEFT:  c.code = CMD_LEFT;
            SC_E_RIGHT: c.code = CMD_RIGHT;
            default:    c.hit  = 1'b0;
         endcase
      end else begin
         case (sc)
            SC_W:    c.code = CMD_UP;
            SC_S:    c.code = CMD_DOWN;
            SC_A:    c.code = CMD_LEFT;
            SC_D:    c.code = CMD_RIGHT;
            SC_R:    c.code = CMD_RESTART;
            default: c.hit  = 1'b0;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: line synchronisers, ps2_clk glitch filter, 11-bit frame
// FSM with odd-parity/stop check and an inter-edge watchdog.
module ps2_rx
   import game_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err,
   output logic       timeout
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    clk_sync_reg;
   logic [1:0]    data_sync_reg;
   logic [FW-1:0] filt_cnt_reg;
   logic          filt_level_reg;
   logic          fall_reg;
   logic          fall_data_reg;
   rx_state_t     state_reg;
   logic [2:0]    bit_cnt_reg;
   logic [7:0]    shift_reg;
   logic          parity_reg;
   logic [WW-1:0] wd_cnt_reg;
   logic          stop_seen;
   logic          frame_good;

   // Strobes are decoded from the fall cycle so the top can register the
   // resulting command one cycle after the stop bit is sampled.
   always_comb begin
      stop_seen  = fall_reg && (state_reg == ST_STOP);
      frame_good = fall_data_reg && (^{shift_reg, parity_reg});
      timeout    = (state_reg != ST_IDLE) && !fall_reg &&
                   (wd_cnt_reg == WW'(TIMEOUT_CYCLES - 1));
      byte_valid = stop_seen && frame_good;
      frame_err  = (stop_seen && !frame_good) || timeout;
      byte_data  = shift_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_reg   <= 2'b11;
         data_sync_reg  <= 2'b11;
         filt_cnt_reg   <= '0;
         filt_level_reg <= 1'b1;
         fall_reg       <= 1'b0;
         fall_data_reg  <= 1'b0;
         state_reg      <= ST_IDLE;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         parity_reg     <= 1'b0;
         wd_cnt_reg     <= '0;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
         data_sync_reg <= {data_sync_reg[0], ps2_data};
         fall_reg      <= 1'b0;

         // Level flips only after FILTER_LEN consecutive differing samples.
         if (clk_sync_reg[1] == filt_level_reg) begin
            filt_cnt_reg <= '0;
         end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
            filt_cnt_reg   <= '0;
            filt_level_reg <= clk_sync_reg[1];
            fall_reg       <= ~clk_sync_reg[1];
            fall_data_reg  <= data_sync_reg[1];
         end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
         end

         if (fall_reg) begin
            case (state_reg)
               ST_IDLE: begin
                  if (!fall_data_reg) begin
                     state_reg   <= ST_DATA;
                     bit_cnt_reg <= '0;
                  end
               end
               ST_DATA: begin
                  shift_reg   <= {fall_data_reg, shift_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == 3'd7) state_reg <= ST_PARITY;
               end
               ST_PARITY: begin
                  parity_reg <= fall_data_reg;
                  state_reg  <= ST_STOP;
               end
               default: state_reg <= ST_IDLE;
            endcase
         end

         if (state_reg == ST_IDLE || fall_reg) begin
            wd_cnt_reg <= '0;
         end else if (timeout) begin
            wd_cnt_reg  <= '0;
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
         end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard to 2048 command decoder: E0/F0 prefix tracking and a one-deep
// valid/ready command register that drops commands arriving while full.
module ps2_move_decoder
   import game_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   input  logic       cmd_ready,
   output logic       frame_err,
   output logic       cmd_dropped
);

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       rx_err;
   logic       rx_timeout;
   logic       ext_reg;
   logic       brk_reg;
   logic       cmd_valid_reg;
   logic [2:0] cmd_code_reg;
   logic       frame_err_reg;
   logic       cmd_dropped_reg;
   logic       is_prefix;
   logic       new_cmd;
   cmd_t       dec;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (rx_err),
      .timeout    (rx_timeout)
   );

   always_comb begin
      dec       = decode_scan(byte_data, ext_reg);
      is_prefix = (byte_data == SC_EXT) || (byte_data == SC_BRK);
      new_cmd   = byte_valid && !is_prefix && !brk_reg && dec.hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_reg         <= 1'b0;
         brk_reg         <= 1'b0;
         cmd_valid_reg   <= 1'b0;
         cmd_code_reg    <= '0;
         frame_err_reg   <= 1'b0;
         cmd_dropped_reg <= 1'b0;
      end else begin
         frame_err_reg   <= rx_err;
         cmd_dropped_reg <= 1'b0;

         if (rx_timeout) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
         end else if (byte_valid) begin
            if (byte_data == SC_EXT) begin
               ext_reg <= 1'b1;
            end else if (byte_data == SC_BRK) begin
               brk_reg <= 1'b1;
            end else begin
               ext_reg <= 1'b0;
               brk_reg <= 1'b0;
            end
         end

         // A command replaces the pending one only if that one leaves this cycle.
         if (new_cmd) begin
            if (!cmd_valid_reg || cmd_ready) begin
               cmd_valid_reg <= 1'b1;
               cmd_code_reg  <= dec.code;
            end else begin
               cmd_dropped_reg <= 1'b1;
            end
         end else if (cmd_valid_reg && cmd_ready) begin
            cmd_valid_reg <= 1'b0;
         end
      end
   end

   assign cmd_valid   = cmd_valid_reg;
   assign cmd_code    = cmd_code_reg;
   assign frame_err   = frame_err_reg;
   assign cmd_dropped = cmd_dropped_reg;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench: bit-bangs PS/2 frames into ps2_move_decoder and checks
// commands, drops and frame errors against hand-computed expectations.
module tb_ps2_move_decoder;

   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic       cmd_ready;
   logic       frame_err;
   logic       cmd_dropped;

   int total = 0;
   int bad   = 0;
   int acc_n = 0;
   int err_n = 0;
   int drop_n = 0;
   int last_code = -1;

   ps2_move_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .cmd_ready   (cmd_ready),
      .frame_err   (frame_err),
      .cmd_dropped (cmd_dropped)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) begin
            acc_n     <= acc_n + 1;
            last_code <= int'(cmd_code);
         end
         if (frame_err)   err_n  <= err_n + 1;
         if (cmd_dropped) drop_n <= drop_n + 1;
      end
   end

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic ps2_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         wait_cyc(3);
         ps2_clk = 1'b0;
         wait_cyc(2);
         ps2_clk = 1'b1;
         wait_cyc(HALF - 5);
      end else begin
         wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      if (glitch) begin
         wait_cyc(6);
         ps2_clk = 1'b1;
         wait_cyc(2);
         ps2_clk = 1'b0;
         wait_cyc(HALF - 8);
      end else begin
         wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit glitch);
      logic par;
      par = ~(^b) ^ flip_par;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch && (i >= 2) && (i <= 5));
      ps2_bit(par, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_data = 1'b1;
      wait_cyc(40);
      $display("frame %02h flip_par=%0d glitch=%0d valid=%0d code=%0d", b, flip_par, glitch,
               cmd_valid, cmd_code);
   endtask

   initial begin
      int a0, e0, d0;
      rst       = 1'b1;
      ps2_clk   = 1'b1;
      ps2_data  = 1'b1;
      cmd_ready = 1'b1;
      wait_cyc(5);
      @(negedge clk);
      check_val("rst_valid", int'(cmd_valid), 0);
      check_val("rst_code", int'(cmd_code), 0);
      check_val("rst_err", int'(frame_err), 0);
      check_val("rst_drop", int'(cmd_dropped), 0);
      rst = 1'b0;
      wait_cyc(20);

      // W make code -> up
      a0 = acc_n; e0 = err_n;
      send_frame(8'h1D, 1'b0, 1'b0);
      check_val("w_acc", acc_n - a0, 1);
      check_val("w_code", last_code, 0);
      check_val("w_err", err_n - e0, 0);

      // extended left, then its break sequence
      a0 = acc_n;
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b0);
      check_val("left_acc", acc_n - a0, 1);
      check_val("left_code", last_code, 2);
      check_val("left_ext", int'(dut.ext_reg), 0);
      check_val("left_brk", int'(dut.brk_reg), 0);

      // R held pending, D dropped, then accepted
      cmd_ready = 1'b0;
      a0 = acc_n; d0 = drop_n;
      send_frame(8'h2D, 1'b0, 1'b0);
      send_frame(8'h23, 1'b0, 1'b0);
      @(negedge clk);
      check_val("hold_valid", int'(cmd_valid), 1);
      check_val("hold_code", int'(cmd_code), 4);
      check_val("hold_drop", drop_n - d0, 1);
      check_val("hold_acc", acc_n - a0, 0);
      cmd_ready = 1'b1;
      wait_cyc(3);
      @(negedge clk);
      check_val("rel_valid", int'(cmd_valid), 0);
      check_val("rel_acc", acc_n - a0, 1);
      check_val("rel_code", last_code, 4);

      // bad parity S, then good S
      a0 = acc_n; e0 = err_n;
      send_frame(8'h1B, 1'b1, 1'b0);
      check_val("par_err", err_n - e0, 1);
      check_val("par_acc", acc_n - a0, 0);
      send_frame(8'h1B, 1'b0, 1'b0);
      check_val("s_code", last_code, 1);
      check_val("s_acc", acc_n - a0, 1);

      // partial frame -> watchdog timeout
      e0 = err_n; a0 = acc_n;
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_data = 1'b1;
      wait_cyc(49900);
      check_val("to_early", err_n - e0, 0);
      wait_cyc(300);
      check_val("to_err", err_n - e0, 1);
      $display("timeout window done err_pulses=%0d", err_n - e0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h74, 1'b0, 1'b0);
      check_val("to_acc", acc_n - a0, 1);
      check_val("to_code", last_code, 3);

      // glitches on ps2_clk shorter than the filter
      a0 = acc_n; e0 = err_n;
      send_frame(8'h1D, 1'b0, 1'b1);
      check_val("gl_acc", acc_n - a0, 1);
      check_val("gl_code", last_code, 0);
      check_val("gl_err", err_n - e0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_move_decoder.md
# ps2_move_decoder

Receives the PS/2 keyboard serial stream, validates each 11-bit frame and turns Scan Code Set 2 make codes into 2048 game commands: up, down, left, right and restart. It sits directly upstream of the game/board logic inside `Top`. The game logic that feeds the VGA output consumes its commands through a valid/ready handshake. Everything runs on the 50 MHz system clock; the PS/2 lines are treated as asynchronous inputs.

## Interface
Parameters:
- `FILTER_LEN`, default 8: number of consecutive identical synchronised samples required before the filtered ps2_clk level changes.
- `TIMEOUT_CYCLES`, default 50000: number of clk cycles without a filtered falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `cmd_valid` out 1: a command is pending.
- `cmd_code` out 3: 0 up, 1 down, 2 left, 3 right, 4 restart; values 5–7 are never driven.
- `cmd_ready` in 1: the consumer accepts `cmd_code` on any cycle where `cmd_valid && cmd_ready`.
- `frame_err` out 1: one-cycle pulse on a parity error, stop-bit error or timeout.
- `cmd_dropped` out 1: one-cycle pulse when a decoded command is discarded because a command is already pending.

## Operation
Input conditioning:
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
- The synchronised `ps2_clk` feeds a saturating filter counter that counts up to `FILTER_LEN`.
- A filtered falling edge (filtered level 1→0) produces a one-cycle `fall` strobe.
- Data is sampled from synchronised `ps2_data` on the `fall` strobe.

Frame FSM:
- IDLE: on `fall` with data=0 (start bit), go to DATA with bit count 0. On `fall` with data=1, stay in IDLE with no error.
- DATA: shift data in LSB-first on each `fall`. After the 8th bit, go to PARITY.
- PARITY: capture the parity bit, then go to STOP.
- STOP: on `fall`, the frame is good only if data=1 and the 8 data bits plus the parity bit contain an odd number of ones. A good frame pushes its byte to the decoder. A bad frame pulses `frame_err`. Either way, return to IDLE.
- Timeout: in any non-IDLE state, a watchdog counts cycles since the last `fall`. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err`, discard the partial byte and return to IDLE. The watchdog resets on every `fall`.

Scan-code decoder (byte-level flags `ext`, `brk`):
- `E0` sets `ext`.
- `F0` sets `brk`.
- Any other byte ends the sequence and clears both flags.
- If `brk` was set when that byte arrived, it produces no command.
- Otherwise, with `ext`=1: `75`→up, `72`→down, `6B`→left, `74`→right.
- With `ext`=0: `1D`(W)→up, `1B`(S)→down, `1C`(A)→left, `23`(D)→right, `2D`(R)→restart.
- Any other code, or an extended code not in the list above, is ignored silently.
- Typematic repeats are fresh make codes, and each one yields a command.

Output register:
- A decoded command loads `cmd_code` and sets `cmd_valid` when `cmd_valid`=0, or when the pending command is being accepted in that same cycle.
- Otherwise the new command is discarded and `cmd_dropped` pulses.
- `cmd_code` is held stable while `cmd_valid`=1.

## Timing
- Reset values: `cmd_valid`=0, `cmd_code`=0, `frame_err`=0, `cmd_dropped`=0, FSM in IDLE, `ext`=`brk`=0, shift register and counters all 0, filtered ps2_clk level=1.
- Edge latency: a raw ps2_clk falling edge produces `fall` 2 (synchroniser) + `FILTER_LEN` cycles later.
- Command latency: `cmd_valid` rises on the cycle after the `fall` that samples the stop bit.
- `frame_err` and `cmd_dropped` are registered and appear on the same cycle `cmd_valid` would have risen.
- Accept and new command on the same cycle: the pending command is consumed and the new command is loaded; `cmd_valid` stays 1 and there is no drop pulse.
- A parity or stop-bit error leaves `ext`/`brk` unchanged. A timeout clears `ext` and `brk`.
- `rst` asserted mid-frame aborts everything on the next edge. No command and no error pulse are produced for the aborted frame.

## Structure
- Shared package `game_pkg`: command encodings `CMD_UP`, `CMD_DOWN`, `CMD_LEFT`, `CMD_RIGHT`, `CMD_RESTART` (3 bits), plus the scan-code constants.
- Sub-module `ps2_rx`: synchronisers, filter, frame FSM and watchdog. It outputs `byte_valid` (pulse), `byte_data[7:0]` and `frame_err`.
- The top level holds the decoder flags and the output handshake register.

## Test plan
- Send frame `1D`, `cmd_ready`=1 → one cycle of `cmd_valid` with `cmd_code`=0; no `frame_err`.
- Send `E0 6B`, then `E0 F0 6B` → exactly one command, `cmd_code`=2. The break sequence yields nothing, and `ext`/`brk` end at 0.
- Send `2D` with `cmd_ready`=0, then `23` → `cmd_valid` held with `cmd_code`=4 and one `cmd_dropped` pulse. Raising `cmd_ready` then drops `cmd_valid`.
- Send `1B` with a flipped parity bit → `frame_err` pulse, no command. A following good `1B` → `cmd_code`=1.
- Send a start bit plus 3 data bits, then idle for 50000 cycles → `frame_err` pulse at the timeout. A subsequent good `E0 74` → `cmd_code`=3.
- Apply 2-cycle glitches on `ps2_clk` (shorter than `FILTER_LEN`) during `1D` → the frame is still decoded correctly, `cmd_code`=0.
